// File: rtl/stream_ser_pkg.sv
// Shared types and helpers for the byte-stream width-converting serializer.
package stream_ser_pkg;

  localparam int unsigned BYTES_DEFAULT = 4;
  localparam int unsigned BYTES_MAX     = 8;

  typedef logic [7:0] byte_t;

  // One-hot of the lowest set bit; narrower masks are zero-extended by the caller.
  function automatic logic [BYTES_MAX-1:0] lsb_onehot(input logic [BYTES_MAX-1:0] mask);
    return mask & (~mask + BYTES_MAX'(1));
  endfunction

endpackage

// File: rtl/stream_ser_lsb_pick.sv
// Lowest-set-bit priority encoder: index of the lowest set bit and an exactly-one-set flag.
module stream_ser_lsb_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign single = (mask != '0) && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/stream_serializer.sv
// Serializes BYTES-wide words onto an 8-bit valid/ready stream, LSB first.
// Optional per-byte keep mask enabled by defining STREAM_SER_KEEP_EN.
module stream_serializer
  import stream_ser_pkg::*;
#(
  parameter int unsigned BYTES = BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid_i,
  input  logic [8*BYTES-1:0] i_data_i,
`ifdef STREAM_SER_KEEP_EN
  input  logic [BYTES-1:0]   i_keep_i,
`endif
  output logic               i_ready_o,
  input  logic               e_ready_i,
  output logic               e_valid_o,
  output logic [7:0]         e_data_o,
  output logic               e_last_o
);

  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned IDX_W = $clog2(BYTES);

  logic [W-1:0]     word_q;
  logic [BYTES-1:0] mask_q;
  logic [BYTES-1:0] mask_load;
  logic [BYTES-1:0] mask_clr;
  logic [IDX_W-1:0] cur;
  logic             single;
  logic             busy;
  logic             i_hs;
  logic             e_hs;

  stream_ser_lsb_pick #(
    .N     (BYTES),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask   (mask_q),
    .idx    (cur),
    .single (single)
  );

  assign busy = |mask_q;

`ifdef STREAM_SER_KEEP_EN
  assign mask_load = i_keep_i;
`else
  assign mask_load = '1;
`endif

  assign mask_clr = mask_q & ~BYTES'(lsb_onehot(BYTES_MAX'(mask_q)));

  assign e_valid_o = busy;
  assign e_last_o  = busy & single;
  // Ready looks through to egress ready so the next word loads as the last byte leaves.
  assign i_ready_o = ~busy | (e_ready_i & e_last_o);

  assign i_hs = i_valid_i & i_ready_o;
  assign e_hs = busy & e_ready_i;

  always_comb begin
    e_data_o = 8'h00;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (busy && (cur == IDX_W'(i))) e_data_o = word_q[8*i +: 8];
    end
  end

  // A load takes priority over clearing the final byte on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      mask_q <= '0;
    end else if (i_hs) begin
      word_q <= i_data_i;
      mask_q <= mask_load;
    end else if (e_hs) begin
      mask_q <= mask_clr;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: accepted words queue their expected bytes,
// a negedge monitor pops and compares on every egress handshake.
module tb_stream_serializer;

  localparam int unsigned BYTES = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_valid_i = 1'b0;
  logic [8*BYTES-1:0] i_data_i = '0;
  logic [BYTES-1:0]   keep_v = '1;
  logic               i_ready_o;
  logic               e_ready_i = 1'b0;
  logic               e_valid_o;
  logic [7:0]         e_data_o;
  logic               e_last_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  stream_serializer #(.BYTES(BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
`ifdef STREAM_SER_KEEP_EN
    .i_keep_i  (keep_v),
`endif
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o),
    .e_last_o  (e_last_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bytes of an accepted word: kept bytes in ascending order, last on highest kept.
  task automatic push_word(input logic [8*BYTES-1:0] w, input logic [BYTES-1:0] k);
    int hi;
    hi = -1;
    for (int i = 0; i < int'(BYTES); i++) if (k[i]) hi = i;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (k[i]) sb.push_back({(i == hi), w[8*i +: 8]});
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] exp;
    if (!reset) begin
      if (i_valid_i && i_ready_o) push_word(i_data_i, keep_v);
      if (e_valid_o) begin
        if (e_ready_i) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", e_data_o);
          end else begin
            exp = sb.pop_front();
            check("egress_data", 64'(e_data_o), 64'(exp[7:0]));
            check("egress_last", 64'(e_last_o), 64'(exp[8]));
          end
        end
      end else begin
        check("idle_data", 64'(e_data_o), 64'h0);
        check("idle_last", 64'(e_last_o), 64'h0);
      end
    end
  end

  initial begin
    logic [7:0] vals [8];
    for (int i = 0; i < 8; i++) vals[i] = 8'(i);

    // Reset then idle
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_i_ready", 64'(i_ready_o), 64'h1);
    check("rst_e_valid", 64'(e_valid_o), 64'h0);
    check("rst_e_data",  64'(e_data_o),  64'h0);
    check("rst_e_last",  64'(e_last_o),  64'h0);

    // Single word, full egress rate
    e_ready_i = 1'b1;
    i_valid_i = 1'b1;
    i_data_i  = 32'hDDCCBBAA;
    tick();
    i_valid_i = 1'b0;
    check("w1_b0", 64'(e_data_o), 64'hAA);
    check("w1_b0_last", 64'(e_last_o), 64'h0);
    tick();
    check("w1_b1", 64'(e_data_o), 64'hBB);
    tick();
    check("w1_b2", 64'(e_data_o), 64'hCC);
    tick();
    check("w1_b3", 64'(e_data_o), 64'hDD);
    check("w1_b3_last", 64'(e_last_o), 64'h1);
    tick();
    check("w1_done_valid", 64'(e_valid_o), 64'h0);

    // Back-to-back words without bubbles
    i_valid_i = 1'b1;
    i_data_i  = 32'h03020100;
    tick();
    i_data_i  = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      check("b2b_valid", 64'(e_valid_o), 64'h1);
      check("b2b_data", 64'(e_data_o), 64'(vals[k]));
      check("b2b_i_ready", 64'(i_ready_o), ((k == 3) || (k == 7)) ? 64'h1 : 64'h0);
      tick();
      if (k == 3) i_valid_i = 1'b0;
    end
    check("b2b_done_valid", 64'(e_valid_o), 64'h0);

    // Egress stall on second byte
    i_valid_i = 1'b1;
    i_data_i  = 32'h44332211;
    tick();
    i_valid_i = 1'b0;
    check("st_b0", 64'(e_data_o), 64'h11);
    tick();
    e_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("st_hold_valid", 64'(e_valid_o), 64'h1);
      check("st_hold_data", 64'(e_data_o), 64'h22);
      check("st_hold_last", 64'(e_last_o), 64'h0);
      check("st_hold_i_ready", 64'(i_ready_o), 64'h0);
      tick();
    end
    e_ready_i = 1'b1;
    check("st_b1", 64'(e_data_o), 64'h22);
    tick();
    check("st_b2", 64'(e_data_o), 64'h33);
    tick();
    check("st_b3", 64'(e_data_o), 64'h44);
    check("st_b3_last", 64'(e_last_o), 64'h1);
    tick();
    check("st_done_valid", 64'(e_valid_o), 64'h0);

    // Reset mid-word discards the remainder
    i_valid_i = 1'b1;
    i_data_i  = 32'h44332211;
    tick();
    i_valid_i = 1'b0;
    check("rm_b0", 64'(e_data_o), 64'h11);
    tick();
    reset = 1'b1;
    sb.delete();
    #1;
    check("rm_i_ready", 64'(i_ready_o), 64'h1);
    check("rm_e_valid", 64'(e_valid_o), 64'h0);
    check("rm_e_data",  64'(e_data_o),  64'h0);
    check("rm_e_last",  64'(e_last_o),  64'h0);
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rm_no_bytes", 64'(e_valid_o), 64'h0);
    end

`ifdef STREAM_SER_KEEP_EN
    // Sparse keep mask
    keep_v    = 4'b1010;
    i_valid_i = 1'b1;
    i_data_i  = 32'hDDCCBBAA;
    tick();
    i_valid_i = 1'b0;
    check("kp_b0", 64'(e_data_o), 64'hBB);
    check("kp_b0_last", 64'(e_last_o), 64'h0);
    tick();
    check("kp_b1", 64'(e_data_o), 64'hDD);
    check("kp_b1_last", 64'(e_last_o), 64'h1);
    tick();
    check("kp_done_valid", 64'(e_valid_o), 64'h0);

    // Empty keep mask is swallowed
    keep_v    = 4'b0000;
    i_valid_i = 1'b1;
    check("kz_i_ready_pre", 64'(i_ready_o), 64'h1);
    tick();
    i_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("kz_valid", 64'(e_valid_o), 64'h0);
      check("kz_i_ready", 64'(i_ready_o), 64'h1);
      tick();
    end
    keep_v = '1;
`endif

    tick();
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
